// File: rtl/line_burst_adaptor.sv
// Splits 256-bit cacheline requests into 4-beat 64-bit memory bursts and reassembles reads.
// Optional burst watchdog and sticky err_o enabled with `define LINE_ADAPTOR_ERR_EN.
module line_burst_adaptor #(
    parameter int s_offset = 5,
    parameter int s_beat   = 64
`ifdef LINE_ADAPTOR_ERR_EN
    ,
    parameter int TIMEOUT  = 255
`endif
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [31:0]               line_addr_i,
    input  logic                      line_read_i,
    input  logic                      line_write_i,
    input  logic [(8<<s_offset)-1:0]  line_wdata_i,
    output logic [(8<<s_offset)-1:0]  line_rdata_o,
    output logic                      line_resp_o,
    output logic [31:0]               burst_addr_o,
    output logic                      burst_read_o,
    output logic                      burst_write_o,
    output logic [s_beat-1:0]         burst_wdata_o,
    input  logic [s_beat-1:0]         burst_rdata_i,
    input  logic                      burst_resp_i,
    output logic                      err_o
);

    localparam int LINE_W = 8 << s_offset;
    localparam int BEATS  = LINE_W / s_beat;
    localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BEATS - 1);
    localparam logic [31:0] ALIGN_MASK = ~((32'd1 << s_offset) - 32'd1);

    typedef enum logic [1:0] {
        IDLE,
        RD_BURST,
        WR_BURST,
        DONE
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [31:0]         addr_q, addr_d;
    logic [LINE_W-1:0]   wbuf_q, wbuf_d;
    logic [LINE_W-1:0]   rbuf_q, rbuf_d;
    logic                wd_hit;

`ifdef LINE_ADAPTOR_ERR_EN
    logic [7:0] wdog_q, wdog_d;
    logic       err_q, err_d;

    // Counts only stalled cycles inside a burst; idle/done states keep it cleared.
    always_comb begin
        wdog_d = '0;
        wd_hit = 1'b0;
        if ((state_q == RD_BURST || state_q == WR_BURST) && !burst_resp_i) begin
            if (wdog_q == 8'(TIMEOUT - 1)) begin
                wd_hit = 1'b1;
            end else begin
                wdog_d = wdog_q + 8'd1;
            end
        end
        err_d = err_q | wd_hit;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wdog_q <= '0;
            err_q  <= 1'b0;
        end else begin
            wdog_q <= wdog_d;
            err_q  <= err_d;
        end
    end

    assign err_o = err_q;
`else
    assign wd_hit = 1'b0;
    assign err_o  = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wbuf_d  = wbuf_q;
        rbuf_d  = rbuf_q;
        unique case (state_q)
            IDLE: begin
                if (line_write_i) begin
                    wbuf_d  = line_wdata_i;
                    addr_d  = line_addr_i & ALIGN_MASK;
                    cnt_d   = '0;
                    state_d = WR_BURST;
                end else if (line_read_i) begin
                    addr_d  = line_addr_i & ALIGN_MASK;
                    cnt_d   = '0;
                    state_d = RD_BURST;
                end
            end
            RD_BURST: begin
                if (burst_resp_i) begin
                    rbuf_d[cnt_q*s_beat +: s_beat] = burst_rdata_i;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST) begin
                        state_d = DONE;
                    end
                end else if (wd_hit) begin
                    cnt_d   = '0;
                    state_d = DONE;
                end
            end
            WR_BURST: begin
                if (burst_resp_i) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST) begin
                        state_d = DONE;
                    end
                end else if (wd_hit) begin
                    cnt_d   = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wbuf_q  <= '0;
            rbuf_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wbuf_q  <= wbuf_d;
            rbuf_q  <= rbuf_d;
        end
    end

    // Read data lives in its own buffer so writes never disturb the returned line.
    assign line_rdata_o  = rbuf_q;
    assign line_resp_o   = (state_q == DONE);
    assign burst_addr_o  = addr_q;
    assign burst_read_o  = (state_q == RD_BURST);
    assign burst_write_o = (state_q == WR_BURST);
    assign burst_wdata_o = (state_q == WR_BURST) ? wbuf_q[cnt_q*s_beat +: s_beat] : '0;

endmodule

// File: tb/tb_line_burst_adaptor.sv
// Directed scoreboard bench for line_burst_adaptor.
// Define LINE_ADAPTOR_ERR_EN to exercise the watchdog (TIMEOUT=8).
module tb_line_burst_adaptor;

    logic         clk;
    logic         rst;
    logic [31:0]  line_addr_i;
    logic         line_read_i;
    logic         line_write_i;
    logic [255:0] line_wdata_i;
    logic [255:0] line_rdata_o;
    logic         line_resp_o;
    logic [31:0]  burst_addr_o;
    logic         burst_read_o;
    logic         burst_write_o;
    logic [63:0]  burst_wdata_o;
    logic [63:0]  burst_rdata_i;
    logic         burst_resp_i;
    logic         err_o;

    int total = 0;
    int bad   = 0;
    logic [255:0] exp_q[$];
    logic [255:0] last_rd = '0;

`ifdef LINE_ADAPTOR_ERR_EN
    line_burst_adaptor #(.TIMEOUT(8)) dut (
`else
    line_burst_adaptor dut (
`endif
        .clk           (clk),
        .rst           (rst),
        .line_addr_i   (line_addr_i),
        .line_read_i   (line_read_i),
        .line_write_i  (line_write_i),
        .line_wdata_i  (line_wdata_i),
        .line_rdata_o  (line_rdata_o),
        .line_resp_o   (line_resp_o),
        .burst_addr_o  (burst_addr_o),
        .burst_read_o  (burst_read_o),
        .burst_write_o (burst_write_o),
        .burst_wdata_o (burst_wdata_o),
        .burst_rdata_i (burst_rdata_i),
        .burst_resp_i  (burst_resp_i),
        .err_o         (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [255:0] obs,
                         input logic [255:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        check({tag, "_resp"}, line_resp_o, 0);
        check({tag, "_rd"}, burst_read_o, 0);
        check({tag, "_wr"}, burst_write_o, 0);
        check({tag, "_addr"}, burst_addr_o, 0);
        check({tag, "_wdata"}, burst_wdata_o, 0);
        check({tag, "_rdata"}, line_rdata_o, 0);
        check({tag, "_err"}, err_o, 0);
    endtask

    function automatic logic [255:0] rand_line();
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[i*32 +: 32] = $urandom;
        return l;
    endfunction

    task automatic do_read(input logic [31:0] a, input logic [255:0] line,
                           input int gap_at, input int gap_len);
        int cyc;
        logic [255:0] e;
        line_addr_i = a;
        line_read_i = 1'b1;
        exp_q.push_back(line);
        cyc = 1;
        tick(); cyc++;
        check("rd_req", burst_read_o, 1);
        check("rd_addr", burst_addr_o, a & 32'hFFFF_FFE0);
        for (int b = 0; b < 4; b++) begin
            if (b == gap_at) begin
                for (int g = 0; g < gap_len; g++) begin
                    burst_resp_i = 1'b0;
                    tick(); cyc++;
                end
            end
            burst_resp_i  = 1'b1;
            burst_rdata_i = line[b*64 +: 64];
            tick(); cyc++;
            burst_resp_i  = 1'b0;
            burst_rdata_i = '0;
        end
        for (int w = 0; w < 8 && line_resp_o !== 1'b1; w++) begin
            tick(); cyc++;
        end
        check("rd_resp", line_resp_o, 1);
        check("rd_lat", cyc, 6 + gap_len);
        check("rd_drop", burst_read_o, 0);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
        check("rd_line", line_rdata_o, e);
        last_rd = e;
        tick();
        check("rd_pulse", line_resp_o, 0);
        check("rd_hold", line_rdata_o, e);
        line_read_i = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [255:0] line,
                            input int gap_at, input int gap_len,
                            input bit also_rd);
        int cyc;
        logic [255:0] cap;
        logic [255:0] e;
        cap = '0;
        line_addr_i  = a;
        line_wdata_i = line;
        line_write_i = 1'b1;
        line_read_i  = also_rd;
        exp_q.push_back(line);
        cyc = 1;
        tick(); cyc++;
        check("wr_req", burst_write_o, 1);
        check("wr_addr", burst_addr_o, a & 32'hFFFF_FFE0);
        for (int b = 0; b < 4; b++) begin
            if (b == gap_at) begin
                for (int g = 0; g < gap_len; g++) begin
                    burst_resp_i = 1'b0;
                    check("wr_stall", burst_wdata_o, line[b*64 +: 64]);
                    tick(); cyc++;
                end
            end
            check("wr_beat", burst_wdata_o, line[b*64 +: 64]);
            check("wr_no_rd", burst_read_o, 0);
            cap[b*64 +: 64] = burst_wdata_o;
            burst_resp_i = 1'b1;
            tick(); cyc++;
            burst_resp_i = 1'b0;
        end
        for (int w = 0; w < 8 && line_resp_o !== 1'b1; w++) begin
            tick(); cyc++;
        end
        check("wr_resp", line_resp_o, 1);
        check("wr_lat", cyc, 6 + gap_len);
        check("wr_drop", burst_write_o, 0);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
        check("wr_line", cap, e);
        tick();
        check("wr_pulse", line_resp_o, 0);
        line_write_i = 1'b0;
        line_read_i  = 1'b0;
    endtask

    initial begin
        logic [255:0] rl;
        logic [255:0] wl;
        bit ok;
        rst = 1'b1;
        line_addr_i = '0;
        line_read_i = 1'b0;
        line_write_i = 1'b0;
        line_wdata_i = '0;
        burst_rdata_i = '0;
        burst_resp_i = 1'b0;
        tick(); tick();
        chk_zero("reset");
        rst = 1'b0;
        tick();
        chk_zero("post_reset");

        rl = {64'h3333_3333_3333_3333, 64'h2222_2222_2222_2222,
              64'h1111_1111_1111_1111, 64'h0000_0000_0000_0000};
        do_read(32'h0000_125C, rl, 4, 0);

        wl = {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
              64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
        do_write(32'h0000_2001, wl, 2, 2, 1'b0);
        check("rd_untouched", line_rdata_o, rl);

        do_write(32'hFFFF_FFFF, rand_line(), 4, 0, 1'b1);

        do_write(32'h0000_4040, rand_line(), 4, 0, 1'b0);
        do_read(32'h0000_4040, rand_line(), 4, 0);

        do_read(32'h1234_5678, rand_line(), 0, 3);
        do_read(32'h8000_001F, rand_line(), 3, 1);

        line_addr_i = 32'h0000_8000;
        line_read_i = 1'b1;
        tick();
        burst_resp_i  = 1'b1;
        burst_rdata_i = 64'h0123_4567_89AB_CDEF;
        tick();
        burst_rdata_i = 64'hFEDC_BA98_7654_3210;
        tick();
        burst_rdata_i = 64'h5555_AAAA_5555_AAAA;
        #2 rst = 1'b1;
        #1;
        chk_zero("mid_rst");
        burst_resp_i = 1'b0;
        line_read_i  = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        do_read(32'h0000_8000, rand_line(), 4, 0);

`ifdef LINE_ADAPTOR_ERR_EN
        line_addr_i = 32'h0000_9000;
        line_read_i = 1'b1;
        tick();
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k < 8) check("to_wait", line_resp_o, 0);
        end
        check("to_resp", line_resp_o, 1);
        check("to_err", err_o, 1);
        check("to_stale", line_rdata_o, last_rd);
        tick();
        line_read_i = 1'b0;
        check("to_pulse", line_resp_o, 0);
        check("to_sticky", err_o, 1);
        do_read(32'h0000_A000, rand_line(), 1, 2);
        check("to_sticky2", err_o, 1);
        rst = 1'b1;
        #1;
        check("to_clear", err_o, 0);
        tick();
        rst = 1'b0;
        tick();
`else
        line_addr_i = 32'h0000_9000;
        line_read_i = 1'b1;
        tick();
        ok = 1'b1;
        for (int k = 0; k < 300; k++) begin
            if (burst_read_o !== 1'b1 || line_resp_o !== 1'b0 || err_o !== 1'b0)
                ok = 1'b0;
            tick();
        end
        check("hang_hold", ok, 1);
        check("hang_err", err_o, 0);
        rst = 1'b1;
        line_read_i = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        chk_zero("hang_rst");
`endif

        check("sb_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/line_burst_adaptor.md
# line_burst_adaptor

Converts single-transfer 256-bit cacheline requests from the LLC cache's pmem port into 4-beat 64-bit bursts for physical memory, and reassembles read bursts into a full line. Sits directly downstream of the cache: cache pmem_* outputs drive this block's line-side inputs; its burst side drives the burst memory model or DRAM controller.

## Interface
- s_offset, 5, cacheline offset bits; line = 2**s_offset bytes = 256 bits
- s_beat, 64, burst beat width in bits; beats = 256/s_beat = 4
- TIMEOUT, 255, max cycles without burst_resp_i inside a burst (used only with LINE_ADAPTOR_ERR_EN)

- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- line_addr_i  in  32  line address from cache (pmem_address)
- line_read_i  in  1  line read request
- line_write_i  in  1  line write request
- line_wdata_i  in  256  line to write (llc_cacheline)
- line_rdata_o  out  256  assembled read line
- line_resp_o  out  1  one-cycle completion pulse
- burst_addr_o  out  32  line-aligned burst address
- burst_read_o  out  1  burst read request
- burst_write_o  out  1  burst write request
- burst_wdata_o  out  64  current write beat
- burst_rdata_i  in  64  current read beat
- burst_resp_i  in  1  beat accepted/valid
- err_o  out  1  sticky timeout flag

## Operation
- States: IDLE, RD_BURST, WR_BURST, DONE.
- IDLE: if line_write_i, latch line_wdata_i into line buffer, latch {line_addr_i[31:5], 5'b0} into address register, beat counter = 0, go WR_BURST. Else if line_read_i, latch address likewise, counter = 0, go RD_BURST. Write has priority if both asserted. burst_resp_i ignored in IDLE.
- RD_BURST: burst_read_o = 1. Each cycle with burst_resp_i = 1: buffer[cnt*64 +: 64] <= burst_rdata_i, cnt++. Beat 0 = bits [63:0]. On 4th beat go DONE.
- WR_BURST: burst_write_o = 1, burst_wdata_o = buffer[cnt*64 +: 64]. Each burst_resp_i = 1 advances cnt; on 4th beat go DONE.
- DONE: line_resp_o = 1 for exactly one cycle, then IDLE. line_rdata_o = buffer, held stable from DONE until next read's first beat is captured.
- Counter is 2 bits; wraps to 0 at end of each burst, never exceeds 3.
- burst_addr_o = address register, stable for the whole burst.
- Requests arriving while not in IDLE are not sampled; cache holds requests until line_resp_o, and drops them the cycle after.

## Timing
- Request sampled at edge T (state IDLE) -> burst_read_o/burst_write_o high from T+1.
- Back-to-back resp beats: line_resp_o at cycle (last beat edge)+1; minimum read/write latency = 6 cycles request-to-resp (1 latch + 4 beats + DONE).
- burst_read_o/burst_write_o drop in the DONE cycle; never both high.
- Gaps (burst_resp_i low) inside a burst stall the counter; no data lost.
- All outputs registered or decoded from state only; no combinational path burst_resp_i -> burst_*_o.
- Reset (any time, including mid-burst): state IDLE, cnt 0, line_resp_o 0, burst_read_o 0, burst_write_o 0, burst_addr_o 0, burst_wdata_o 0, line_rdata_o 0, err_o 0. A burst interrupted by reset is abandoned; memory side is reset concurrently.

## Configuration
- LINE_ADAPTOR_ERR_EN defined: 8-bit watchdog counts cycles in RD_BURST/WR_BURST with burst_resp_i low, cleared on every beat and on burst entry. Reaching TIMEOUT forces DONE (line_resp_o pulses so cache does not hang), sets err_o sticky until rst; unfilled read beats keep stale buffer contents.
- Not defined: no watchdog logic; err_o tied 0; bursts wait indefinitely.

## Test plan
- Read, memory returns beats 64'h0..0 through 64'h3..3 on consecutive cycles -> line_rdata_o = {3..3,2..2,1..1,0..0}, line_resp_o single pulse 6 cycles after request, burst_addr_o = 0x0000_1240 for line_addr_i 0x0000_125C.
- Write line 256'h{DDDD..,CCCC..,BBBB..,AAAA..} with burst_resp_i stalled 2 cycles before beat 2 -> burst_wdata_o sequence AAAA,BBBB,CCCC(held 3 cycles),DDDD; resp at cycle 8.
- line_read_i and line_write_i both high in IDLE -> write burst only, burst_read_o stays 0.
- rst asserted during beat 2 of a read -> all outputs 0 asynchronously; next read completes normally with fresh data.
- Back-to-back: write then read issued the cycle after line_resp_o -> read begins IDLE->RD_BURST with no lost/duplicated beats.
- With LINE_ADAPTOR_ERR_EN, TIMEOUT=8, burst_resp_i never asserted -> line_resp_o pulses after 8 idle cycles, err_o = 1 and stays 1 until rst; without macro, burst_read_o remains high indefinitely, err_o = 0.
